// File: rtl/cargador_programa_if.sv
// Byte-stream handshake and memory-bus signals of the CPUCR program loader.
// master = loader side, slave = stream source / memory / CPU side.
interface cargador_programa_if #(
  parameter int ADDR_W = 16
) ();
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] Direccion;
  logic              LE;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, Direccion, LE, cpu_hold, done, error
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, Direccion, LE, cpu_hold, done, error
  );
endinterface

// File: rtl/cargador_programa.sv
// CPUCR program loader: parses SYNC/ADDR/LEN framed bytes and writes the payload to memory.
// Optional trailing checksum byte enabled with `define CARGADOR_CHECKSUM_EN.
module cargador_programa #(
  parameter logic [7:0] SYNC   = 8'hA5,
  parameter int         ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cargador_programa_if.master    bus,
  inout  wire  [7:0]             Datos
);

`ifdef CARGADOR_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_HDR_AH, S_HDR_AL, S_HDR_LH, S_HDR_LL,
    S_WAIT_B, S_SETUP, S_STROBE, S_RELEASE, S_FIN, S_CHK
  } state_t;
  localparam state_t S_TAIL = S_CHK;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_HDR_AH, S_HDR_AL, S_HDR_LH, S_HDR_LL,
    S_WAIT_B, S_SETUP, S_STROBE, S_RELEASE, S_FIN
  } state_t;
  localparam state_t S_TAIL = S_FIN;
`endif

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        data_q, data_d;
  logic              accept;
  logic              ready_st;
  logic              drive_en;
  logic              le;
`ifdef CARGADOR_CHECKSUM_EN
  logic              err_q, err_d;
  logic [7:0]        sum_q, sum_d;
`endif

  assign accept = bus.byte_valid & bus.byte_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept && bus.byte_in == SYNC) state_d = S_HDR_AH;
      S_HDR_AH:  if (accept) state_d = S_HDR_AL;
      S_HDR_AL:  if (accept) state_d = S_HDR_LH;
      S_HDR_LH:  if (accept) state_d = S_HDR_LL;
      S_HDR_LL:  if (accept) state_d = ({rem_q[15:8], bus.byte_in} == 16'd0) ? S_TAIL : S_WAIT_B;
      S_WAIT_B:  if (accept) state_d = S_SETUP;
      S_SETUP:   state_d = S_STROBE;
      S_STROBE:  state_d = S_RELEASE;
      S_RELEASE: state_d = (rem_q == 16'd1) ? S_TAIL : S_WAIT_B;
`ifdef CARGADOR_CHECKSUM_EN
      S_CHK:     if (accept) state_d = S_FIN;
`endif
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_st = 1'b0;
    drive_en = 1'b0;
    le       = 1'b1;
    case (state_q)
      S_IDLE, S_HDR_AH, S_HDR_AL, S_HDR_LH, S_HDR_LL, S_WAIT_B: ready_st = 1'b1;
`ifdef CARGADOR_CHECKSUM_EN
      S_CHK:    ready_st = 1'b1;
`endif
      S_SETUP:  drive_en = 1'b1;
      S_STROBE: begin
        drive_en = 1'b1;
        le       = 1'b0;
      end
      default: ;
    endcase
  end

  // Address/data are captured on byte acceptance so they settle a full cycle before LE falls
  always_comb begin
    armed_d = 1'b1;
    hold_d  = hold_q;
    done_d  = done_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
`ifdef CARGADOR_CHECKSUM_EN
    err_d   = err_q;
    sum_d   = accept ? sum_q + bus.byte_in : sum_q;
`endif
    case (state_q)
      S_IDLE: if (accept && bus.byte_in == SYNC) begin
        hold_d = 1'b1;
        done_d = 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
        err_d  = 1'b0;
        sum_d  = 8'h00;
`endif
      end
      S_HDR_AH: if (accept) ptr_d = ADDR_W'({bus.byte_in, 8'h00});
      S_HDR_AL: if (accept) ptr_d = ptr_q | ADDR_W'(bus.byte_in);
      S_HDR_LH: if (accept) rem_d = {bus.byte_in, 8'h00};
      S_HDR_LL: if (accept) rem_d = {rem_q[15:8], bus.byte_in};
      S_WAIT_B: if (accept) begin
        data_d = bus.byte_in;
        dir_d  = ptr_q;
      end
      S_RELEASE: begin
        ptr_d = ptr_q + ADDR_W'(1);
        rem_d = rem_q - 16'd1;
      end
      S_FIN: begin
        hold_d = 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
        if (sum_q == 8'h00) done_d = 1'b1;
        else                err_d  = 1'b1;
`else
        done_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= '0;
`ifdef CARGADOR_CHECKSUM_EN
      err_q   <= 1'b0;
`endif
    end else begin
      armed_q <= armed_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
`ifdef CARGADOR_CHECKSUM_EN
      err_q   <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    ptr_q  <= ptr_d;
    rem_q  <= rem_d;
    data_q <= data_d;
`ifdef CARGADOR_CHECKSUM_EN
    sum_q  <= sum_d;
`endif
  end

  assign bus.byte_ready = armed_q & ready_st;
  assign bus.Direccion  = dir_q;
  assign bus.LE         = le;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
`ifdef CARGADOR_CHECKSUM_EN
  assign bus.error      = err_q;
`else
  assign bus.error      = 1'b0;
`endif
  assign Datos = drive_en ? data_q : 8'hzz;

endmodule

// File: tb/tb_cargador_programa.sv
// Bench for cargador_programa: directed frames plus random frames against a frame-parsing model.
module tb_cargador_programa;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cargador_programa_if #(.ADDR_W(16)) bus ();
  wire  [7:0] datos;
  logic       tb_en  = 1'b0;
  logic [7:0] tb_val = 8'h00;
  assign datos = tb_en ? tb_val : 8'hzz;

  cargador_programa #(.SYNC(8'hA5), .ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .Datos (datos)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory model: captures Datos at Direccion on every LE falling edge
  logic [7:0]  mem [logic [15:0]];
  int          falls = 0;
  logic [15:0] last_dir;
  logic [7:0]  last_dat;
  always @(negedge clk) begin
    last_dir = bus.Direccion;
    last_dat = datos;
  end
  always @(negedge bus.LE) begin
    chk("stable_addr", bus.Direccion, last_dir);
    chk("stable_data", datos, last_dat);
    mem[bus.Direccion] = datos;
    falls++;
  end

  // Reference model: parse the stream as a frame and derive the expected outcome
  logic [7:0] stream [$];
  logic [7:0] exp_mem [logic [15:0]];
  int         exp_falls;
  logic       exp_done, exp_err;

  task automatic model_frame();
    int          i = 0;
    logic [15:0] a, n;
    logic [7:0]  s;
    exp_mem.delete();
    while (i < stream.size() && stream[i] != 8'hA5) i++;
    i++;
    a = {stream[i], stream[i+1]};
    n = {stream[i+2], stream[i+3]};
    s = 8'(stream[i] + stream[i+1] + stream[i+2] + stream[i+3]);
    i += 4;
    for (int k = 0; k < int'(n); k++) begin
      exp_mem[a + 16'(k)] = stream[i+k];
      s = 8'(s + stream[i+k]);
    end
    exp_falls = int'(n);
`ifdef CARGADOR_CHECKSUM_EN
    s = 8'(s + stream[i + int'(n)]);
    exp_done = (s == 8'h00);
    exp_err  = (s != 8'h00);
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
`endif
  endtask

  task automatic add_chk(input bit good);
`ifdef CARGADOR_CHECKSUM_EN
    logic [7:0] c = 8'h00;
    int         i = 0;
    while (stream[i] != 8'hA5) i++;
    for (int k = i + 1; k < stream.size(); k++) c = 8'(c + stream[k]);
    stream.push_back(good ? 8'(8'h00 - c) : 8'(8'h01 - c));
`else
    if (good) return;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("byte_ready", bus.byte_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic chk_bus_free(input string tag);
    tb_val = 8'hC3;
    tb_en  = 1'b1;
    #1;
    chk(tag, datos, 8'hC3);
    tb_en  = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_stream(input string name);
    logic [15:0] dir_before;
    int          sync_idx = -1;
    int          n = 0;
    mem.delete();
    falls = 0;
    model_frame();
    dir_before = bus.Direccion;
    foreach (stream[k]) begin
      send_byte(stream[k], 2);
      if (sync_idx < 0 && stream[k] == 8'hA5) begin
        sync_idx = k;
        chk({name, "_hold_on"}, bus.cpu_hold, 1'b1);
        chk({name, "_done_clr"}, {bus.done, bus.error}, 2'b00);
      end
    end
    while (!(bus.done || bus.error) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, bus.done, exp_done);
    chk({name, "_error"}, bus.error, exp_err);
    chk({name, "_hold_off"}, bus.cpu_hold, 1'b0);
    chk({name, "_le_falls"}, falls, exp_falls);
    chk({name, "_nwrites"}, mem.num(), exp_mem.num());
    foreach (exp_mem[a])
      chk({name, "_mem"}, mem.exists(a) ? {1'b1, mem[a]} : 9'h000, {1'b1, exp_mem[a]});
    if (exp_falls == 0) chk({name, "_dir_hold"}, bus.Direccion, dir_before);
    chk_bus_free({name, "_datos_z"});
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_le", bus.LE, 1'b1);
    chk("rst_hold", bus.cpu_hold, 1'b0);
    chk("rst_ready", bus.byte_ready, 1'b0);
    chk("rst_done_err", {bus.done, bus.error}, 2'b00);
    chk("rst_dir", bus.Direccion, 16'h0000);
    chk_bus_free("rst_datos_z");
    reset = 1'b0;
    chk("rst_ready_after", bus.byte_ready, 1'b0);
    @(negedge clk);
    chk("idle_ready", bus.byte_ready, 1'b1);

    stream = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    add_chk(1'b1);
    run_stream("three");

    stream = '{8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB};
    add_chk(1'b1);
    run_stream("wrap");

    stream = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00};
    add_chk(1'b1);
    run_stream("len0");

`ifdef CARGADOR_CHECKSUM_EN
    stream = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h05, 8'hEA};
    run_stream("chk_ok");
    stream = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h05, 8'hEB};
    run_stream("chk_bad");
`endif

    // Reset while the second of three payload bytes is being strobed
    mem.delete();
    falls  = 0;
    stream = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h03, 8'h11, 8'h22};
    foreach (stream[k]) send_byte(stream[k], 0);
    n = 0;
    while (bus.LE && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("mid_strobe_seen", bus.LE, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_le", bus.LE, 1'b1);
    chk("mid_rst_hold", bus.cpu_hold, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk_bus_free("mid_rst_datos_z");
    reset = 1'b0;
    chk("mid_rst_first", mem.exists(16'h0030) ? {1'b1, mem[16'h0030]} : 9'h000, 9'h111);
    chk("mid_rst_no_third", mem.exists(16'h0032), 0);
    chk("mid_rst_falls", falls, 2);
    repeat (2) @(negedge clk);

    for (int f = 0; f < 20; f++) begin
      logic [15:0] addr;
      logic [7:0]  b;
      int          len;
      stream.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        stream.push_back(b == 8'hA5 ? 8'h00 : b);
      end
      addr = ($urandom_range(0, 2) == 0) ? 16'hFFFE : 16'($urandom);
      len  = $urandom_range(0, 5);
      stream.push_back(8'hA5);
      stream.push_back(addr[15:8]);
      stream.push_back(addr[7:0]);
      stream.push_back(8'h00);
      stream.push_back(8'(len));
      for (int k = 0; k < len; k++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
        stream.push_back(b);
      end
      add_chk($urandom_range(0, 3) != 0);
      run_stream("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
